// File: rtl/adder_pkg.sv
// Shared widths, FSM state encoding and LFSR taps for the adder driver.
package adder_pkg;
  localparam int DATA_W = 4;
  localparam int RES_W = 7;
  // Fibonacci taps on bits 7, 5, 4 and 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    HOLD,
    CHECK,
    DONE
  } drv_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/adder_lfsr8.sv
// 8-bit Fibonacci LFSR shifting left. Load has priority over step.
module adder_lfsr8
  import adder_pkg::*;
#(
  parameter logic [7:0] INIT = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= INIT;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/adder_driver.sv
// Drives pseudo-random operand pairs into an external adder and counts runs.
// Compare logic (expected register, err_cnt, pass) only with ADDER_DRV_SCOREBOARD_EN.
module adder_driver
  import adder_pkg::*;
#(
  parameter int         N_TXN = 16,
  parameter logic [7:0] SEED  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              valid,
  input  logic [RES_W-1:0]  c,
  output logic              busy,
  output logic              done,
  output logic [7:0]        txn_cnt,
  output logic [7:0]        err_cnt,
  output logic              pass,
  output drv_state_t        dbg_state
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] TXN_LAST = 8'(N_TXN - 1);

  drv_state_t state, state_nxt;
  logic       lfsr_load;
  logic       lfsr_step;
  logic [7:0] lfsr_q;

  // Handshake: valid is a one-cycle strobe in DRIVE with no ready. a/b stay
  // stable through HOLD and CHECK; the adder presents its sum on c by the
  // edge ending HOLD, and c is sampled at the edge ending CHECK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
          lfsr_load = 1'b1;
        end
      end
      DRIVE: state_nxt = HOLD;
      HOLD:  state_nxt = CHECK;
      CHECK: begin
        lfsr_step = 1'b1;
        state_nxt = (txn_cnt == TXN_LAST) ? DONE : DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  adder_lfsr8 #(
    .INIT(SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .load (lfsr_load),
    .seed (SEED_EFF),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  assign dbg_state = state;
  assign busy      = (state == DRIVE) || (state == HOLD) || (state == CHECK);
  assign done      = (state == DONE);
  assign valid     = (state == DRIVE);
  assign a         = busy ? lfsr_q[DATA_W-1:0] : '0;
  assign b         = busy ? lfsr_q[2*DATA_W-1:DATA_W] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_cnt <= '0;
    end else if (lfsr_load) begin
      txn_cnt <= '0;
    end else if (state == CHECK) begin
      txn_cnt <= txn_cnt + 8'd1;
    end
  end

`ifdef ADDER_DRV_SCOREBOARD_EN
  logic [RES_W-1:0] expected;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected <= '0;
      err_cnt  <= '0;
    end else begin
      if (state == DRIVE) begin
        expected <= {{(RES_W-DATA_W){1'b0}}, a} + {{(RES_W-DATA_W){1'b0}}, b};
      end
      if (lfsr_load) begin
        err_cnt <= '0;
      end else if ((state == CHECK) && (c != expected) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign pass = done && (err_cnt == 8'd0);
`else
  logic unused_c;
  assign unused_c = ^c;
  assign err_cnt  = '0;
  assign pass     = done;
`endif

endmodule

// File: tb/tb_adder_driver.sv
// Directed bench for adder_driver: table-driven run checks plus reset/restart sequences.
module tb_adder_driver;
  import adder_pkg::*;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [6:0] sum;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic       fault;

  logic [3:0] a0, b0, a1, b1;
  logic       valid0, valid1, busy0, busy1, done0, done1, pass0, pass1;
  logic [6:0] c0, c1, c0_reg, c1_reg;
  logic       vd0, vd1;
  logic [7:0] txn0, txn1, err0, err1;
  drv_state_t st0, st1;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  adder_driver #(.N_TXN(4), .SEED(8'hA5)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .valid(valid0),
    .c(c0), .busy(busy0), .done(done0), .txn_cnt(txn0), .err_cnt(err0),
    .pass(pass0), .dbg_state(st0)
  );

  adder_driver #(.N_TXN(1), .SEED(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .valid(valid1),
    .c(c1), .busy(busy1), .done(done1), .txn_cnt(txn1), .err_cnt(err1),
    .pass(pass1), .dbg_state(st1)
  );

  // Adder models: sum appears on c at the edge after valid's cycle ends
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      vd0 <= 1'b0; vd1 <= 1'b0; c0_reg <= '0; c1_reg <= '0;
    end else begin
      vd0 <= valid0;
      vd1 <= valid1;
      if (vd0) c0_reg <= {3'b0, a0} + {3'b0, b0};
      if (vd1) c1_reg <= {3'b0, a1} + {3'b0, b1};
    end
  end
  assign c0 = fault ? 7'd0 : c0_reg;
  assign c1 = c1_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called at the negedge inside DRIVE of the first transaction; returns in DONE.
  task automatic run_check(input bit chk_c);
    for (int i = 0; i < 4; i++) begin
      check("drv_valid", valid0, 1);
      check("drv_a", a0, vecs[i].a);
      check("drv_b", b0, vecs[i].b);
      check("drv_txn_cnt", txn0, i);
      @(negedge clk);
      check("hold_valid", valid0, 0);
      check("hold_a", a0, vecs[i].a);
      check("hold_busy", busy0, 1);
      @(negedge clk);
      if (chk_c) check("check_c", c0, vecs[i].sum);
      check("check_state", 32'(st0), 32'(CHECK));
      check("check_done_low", done0, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h5, 4'hA, 7'h0F};
    vecs[1] = '{4'hA, 4'h4, 7'h0E};
    vecs[2] = '{4'h5, 4'h9, 7'h0E};
    vecs[3] = '{4'hA, 4'h2, 7'h0C};

    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; fault = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(st0), 32'(IDLE));
    check("rst_a", a0, 0);
    check("rst_b", b0, 0);
    check("rst_valid", valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_txn", txn0, 0);
    check("rst_err", err0, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic run: four transactions, DONE twelve cycles after DRIVE entry
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("first_state", 32'(st0), 32'(DRIVE));
    run_check(1'b1);
    check("done_rise", done0, 1);
    check("done_busy", busy0, 0);
    check("done_txn", txn0, 4);
    check("done_err", err0, 0);
    check("done_pass", pass0, 1);
    check("done_a", a0, 0);
    check("done_b", b0, 0);
    @(negedge clk);
    check("done_hold", 32'(st0), 32'(DONE));

    // start held through a whole run: one run, then reloaded re-entry
    start0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("held_busy", busy0, 1);
      check("held_valid", valid0, (k % 3) == 0);
      if (k == 3) check("held_a_advances", a0, 4'hA);
    end
    @(negedge clk);
    check("held_done", done0, 1);
    @(negedge clk);
    start0 = 1'b0;
    check("reentry_valid", valid0, 1);
    check("reentry_a", a0, 4'h5);
    check("reentry_b", b0, 4'hA);
    check("reentry_txn", txn0, 0);
    repeat (12) @(negedge clk);
    check("reentry_done", done0, 1);

    // Stuck-at-zero adder
    fault = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    run_check(1'b0);
    check("fault_done", done0, 1);
    check("fault_txn", txn0, 4);
`ifdef ADDER_DRV_SCOREBOARD_EN
    check("fault_err", err0, 4);
    check("fault_pass", pass0, 0);
`else
    check("fault_err", err0, 0);
    check("fault_pass", pass0, 1);
`endif
    fault = 1'b0;

    // Restart clears counters, then reset lands in the second HOLD
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("restart_err", err0, 0);
    check("restart_txn", txn0, 0);
    check("restart_a", a0, 4'h5);
    repeat (3) @(negedge clk);
    check("second_drive_txn", txn0, 1);
    @(negedge clk);
    check("second_hold", 32'(st0), 32'(HOLD));
    reset = 1'b0;
    #1;
    check("abort_valid", valid0, 0);
    check("abort_busy", busy0, 0);
    check("abort_txn", txn0, 0);
    check("abort_a", a0, 0);
    check("abort_done", done0, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 32'(st0), 32'(IDLE));
    check("post_rst_done", done0, 0);
    check("post_rst_busy", busy0, 0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("post_rst_a", a0, 4'h5);
    check("post_rst_valid", valid0, 1);

    // SEED=0 and N_TXN=1 instance
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("seed0_valid", valid1, 1);
    check("seed0_a", a1, 4'h1);
    check("seed0_b", b1, 4'h0);
    repeat (2) @(negedge clk);
    check("seed0_c", c1, 7'h01);
    check("seed0_not_done", done1, 0);
    @(negedge clk);
    check("seed0_done", done1, 1);
    check("seed0_txn", txn1, 1);
    check("seed0_err", err1, 0);
    check("seed0_pass", pass1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_driver.md
ADDER_DRIVER -- requirements
Module: adder_driver

Interface
REQ-001 The block SHALL have parameter N_TXN, default 16, meaning the number of operand pairs issued per run (range 1..255).
REQ-002 The block SHALL have parameter SEED, default 8'hA5, meaning the LFSR seed loaded at reset and at each start.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begins a run when sampled high in IDLE.
REQ-006 a  output  4  operand A to the adder.
REQ-007 b  output  4  operand B to the adder.
REQ-008 valid  output  1  high while an operand pair is presented.
REQ-009 c  input  7  result returned by the adder.
REQ-010 busy  output  1  high from leaving IDLE until entering DONE.
REQ-011 done  output  1  high while in DONE.
REQ-012 txn_cnt  output  8  transactions completed in the current run.
REQ-013 err_cnt  output  8  result mismatches in the current run.
REQ-014 pass  output  1  high in DONE when err_cnt == 0.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, HOLD, CHECK and DONE, one cycle each except IDLE and DONE.
REQ-016 IDLE -> DRIVE on start=1; on that edge, load LFSR with SEED (SEED 0 replaced by 8'h01) and clear txn_cnt and err_cnt.
REQ-017 In DRIVE: valid=1, a=lfsr[3:0], b=lfsr[7:4], expected = {3'b0,a}+{3'b0,b} registered; next state HOLD.
REQ-018 In HOLD: valid=0, a and b held; the adder transfers its sum to c on this edge; next state CHECK.
REQ-019 In CHECK: compare c to expected; on mismatch, increment err_cnt, saturating at 255; increment txn_cnt; step the LFSR.
REQ-020 From CHECK, go to DONE if txn_cnt (before increment) == N_TXN-1, else to DRIVE; one transaction = 3 cycles.
REQ-021 The LFSR SHALL be 8-bit Fibonacci, shifting left with feedback l[7]^l[5]^l[4]^l[3] into bit 0 (A5 -> 4A).
REQ-022 In DONE: hold done=1 and all counters; start=1 re-enters DRIVE with the REQ-016 reload; otherwise remain in DONE.
REQ-023 start while busy SHALL be ignored.
REQ-024 a and b SHALL be 0 in IDLE and DONE.

Reset
REQ-025 While reset=0: state=IDLE, a=0, b=0, valid=0, busy=0, done=0, pass=0, txn_cnt=0, err_cnt=0, LFSR=SEED, independent of clk.
REQ-026 Reset asserted mid-run SHALL abort the run immediately with no done pulse; a new start is required after release.

Configuration
REQ-027 Macro ADDER_DRV_SCOREBOARD_EN SHALL compile in the compare logic (REQ-019 compare, err_cnt, pass).
REQ-028 Without ADDER_DRV_SCOREBOARD_EN: no expected register; err_cnt tied 0; pass tied to done; sequencing and txn_cnt unchanged.

Structure
REQ-029 Package adder_pkg SHALL hold DATA_W=4, RES_W=7, the drv_state_t enum and the LFSR tap mask constant.
REQ-030 The LFSR SHALL be sub-module adder_lfsr8 (ports clk, reset, load, seed, step, q); the FSM and scoreboard stay in adder_driver.

Verification
REQ-031 SEED=A5, N_TXN=4, correct adder model, start pulse -> first DRIVE a=5 b=A, expected 0x0F; second a=A b=4, expected 0x0E; done rises 12 cycles after DRIVE entry; err_cnt=0, pass=1.
REQ-032 Adder model with c stuck at 0, N_TXN=4 -> err_cnt=4, pass=0, txn_cnt=4.
REQ-033 reset=0 asserted during the second HOLD, no clock edge -> valid=0, busy=0, txn_cnt=0 immediately; after release, IDLE until start.
REQ-034 start held high through the whole run -> one run only while busy; DONE -> DRIVE re-entry with LFSR reloaded to A5.
REQ-035 SEED=0 -> first a=1, b=0; N_TXN=1 -> done after 3 cycles, txn_cnt=1.
REQ-036 Build without ADDER_DRV_SCOREBOARD_EN, faulty adder -> err_cnt=0, pass=1 in DONE.
